aes_round_sequencer: RTL and testbench

Iterative AES-128 control block that runs one block through the shared round-step datapath: SubBytes, ShiftRows, MixColumns and AddRoundKey, plus the inverse steps when decryption is enabled. It accepts a plaintext and key over a valid/ready handshake and triggers key expansion when the key changes. It caches the eleven round keys, issues one step operation at a time to the datapath, and returns the result over a valid/ready handshake. It sits between the host interface and the step/key-expansion pipeline stages.

---
 rtl/aes_round_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round-step sequencer with a cached round-key bank.
// Define AES_SEQ_DECRYPT_EN to add the in_decrypt port and inverse sequence.
module aes_round_sequencer #(
  parameter int NROUNDS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_block,
  input  logic [127:0]           in_key,
`ifdef AES_SEQ_DECRYPT_EN
  input  logic                   in_decrypt,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           out_block,
  output logic                   kx_start,
  output logic [127:0]           kx_key,
  input  logic                   keys_valid,
  input  logic [128*NROUNDS-1:0] rk_in,
  output logic                   op_valid,
  output logic [2:0]             op_code,
  output logic [127:0]           op_data,
  output logic [127:0]           op_key,
  input  logic                   op_done,
  input  logic [127:0]           op_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYWAIT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } fsm_t;

  localparam logic [2:0] OP_SUB  = 3'd0;
  localparam logic [2:0] OP_SHF  = 3'd1;
  localparam logic [2:0] OP_MIX  = 3'd2;
  localparam logic [2:0] OP_ARK  = 3'd3;
  localparam logic [2:0] OP_ISUB = 3'd4;
  localparam logic [2:0] OP_ISHF = 3'd5;
  localparam logic [2:0] OP_IMIX = 3'd6;
  localparam logic [3:0] LAST_R  = 4'(NROUNDS);

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic         r_loaded;
  logic [127:0] r_bank [0:NROUNDS];
  logic [3:0]   r_round;
  logic [1:0]   r_step;
  logic         r_kx_first;

  logic         w_dec;
  logic         w_last_r;
  logic         w_last_op;
  logic [2:0]   w_code;
  logic [3:0]   w_kidx;
  logic [127:0] w_key;

`ifdef AES_SEQ_DECRYPT_EN
  logic r_dec;
  assign w_dec = r_dec;
`else
  assign w_dec = 1'b0;
`endif

  assign w_last_r  = (r_round == LAST_R);
  assign w_last_op = w_last_r && (r_step == 2'd2);
  // Decrypt walks the key bank from the top down
  assign w_kidx = w_dec ? (LAST_R - r_round) : r_round;
  assign w_key  = r_bank[w_kidx];

  always_comb begin
    w_code = OP_ARK;
    unique case (1'b1)
      (r_round == 4'd0): w_code = OP_ARK;
      (r_round != 4'd0) && w_dec: begin
        unique case (r_step)
          2'd0:    w_code = OP_ISHF;
          2'd1:    w_code = OP_ISUB;
          2'd2:    w_code = OP_ARK;
          default: w_code = OP_IMIX;
        endcase
      end
      (r_round != 4'd0) && !w_dec: begin
        unique case (r_step)
          2'd0:    w_code = OP_SUB;
          2'd1:    w_code = OP_SHF;
          2'd2:    w_code = w_last_r ? OP_ARK : OP_MIX;
          default: w_code = OP_ARK;
        endcase
      end
      default: w_code = OP_ARK;
    endcase
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign op_valid  = (r_fsm == S_ISSUE);
  assign kx_start  = (r_fsm == S_KEYWAIT) && r_kx_first;
  assign kx_key    = r_key;
  assign op_data   = r_state;
  assign out_block = r_state;
  assign op_code   = op_valid ? w_code : 3'd0;
  assign op_key    = op_valid ? w_key : 128'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_state    <= '0;
      r_key      <= '0;
      r_loaded   <= 1'b0;
      r_round    <= '0;
      r_step     <= '0;
      r_kx_first <= 1'b0;
`ifdef AES_SEQ_DECRYPT_EN
      r_dec      <= 1'b0;
`endif
      for (int i = 0; i <= NROUNDS; i++)
        r_bank[i] <= '0;
    end else begin
      unique case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= in_block;
            r_round <= '0;
            r_step  <= '0;
`ifdef AES_SEQ_DECRYPT_EN
            r_dec   <= in_decrypt;
`endif
            if (r_loaded && (in_key == r_key)) begin
              r_fsm <= S_ISSUE;
            end else begin
              r_key      <= in_key;
              r_loaded   <= 1'b0;
              r_kx_first <= 1'b1;
              r_fsm      <= S_KEYWAIT;
            end
          end
        end
        S_KEYWAIT: begin
          // keys_valid is not trusted in the start-pulse cycle
          if (r_kx_first) begin
            r_kx_first <= 1'b0;
          end else if (keys_valid) begin
            r_bank[0] <= r_key;
            for (int i = 1; i <= NROUNDS; i++)
              r_bank[i] <= rk_in[128*(NROUNDS-i) +: 128];
            r_loaded <= 1'b1;
            r_fsm    <= S_ISSUE;
          end
        end
        S_ISSUE: r_fsm <= S_WAIT;
        S_WAIT: begin
          if (op_done) begin
            r_state <= op_result;
            if (w_last_op) begin
              r_fsm <= S_DONE;
            end else begin
              r_fsm <= S_ISSUE;
              if ((r_round == 4'd0) || (r_step == 2'd3)) begin
                r_round <= r_round + 4'd1;
                r_step  <= 2'd0;
              end else begin
                r_step <= r_step + 2'd1;
              end
            end
          end
        end
        S_DONE: begin
          if (out_ready)
            r_fsm <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES reference, step
// datapath and key expander models, per-cycle compare process.
module tb_aes_round_sequencer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_block = '0;
  logic [127:0]  in_key = '0;
`ifdef AES_SEQ_DECRYPT_EN
  logic          in_decrypt = 1'b0;
`endif
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [127:0]  out_block;
  logic          kx_start;
  logic [127:0]  kx_key;
  logic          keys_valid;
  logic [1279:0] rk_in;
  logic          op_valid;
  logic [2:0]    op_code;
  logic [127:0]  op_data;
  logic [127:0]  op_key;
  logic          op_done = 1'b0;
  logic [127:0]  op_result = '0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NROUNDS(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key),
`ifdef AES_SEQ_DECRYPT_EN
    .in_decrypt(in_decrypt),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block),
    .kx_start(kx_start), .kx_key(kx_key),
    .keys_valid(keys_valid), .rk_in(rk_in),
    .op_valid(op_valid), .op_code(op_code),
    .op_data(op_data), .op_key(op_key),
    .op_done(op_done), .op_result(op_result)
  );

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox[gb(s, i)] : sbox[gb(s, i)];
    return r;
  endfunction

  function automatic logic [127:0] shift(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        if (!inv) r[127-8*(w+4*c) -: 8] = gb(s, w + 4*((c+w)%4));
        else      r[127-8*(w+4*((c+w)%4)) -: 8] = gb(s, w + 4*c);
    return r;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3, m0, m1, m2, m3;
    r = '0;
    m0 = inv ? 8'd14 : 8'd2;
    m1 = inv ? 8'd11 : 8'd3;
    m2 = inv ? 8'd13 : 8'd1;
    m3 = inv ? 8'd9  : 8'd1;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1);
      a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      r[127-32*c -: 8]  = gmul(a0,m0)^gmul(a1,m1)^gmul(a2,m2)^gmul(a3,m3);
      r[119-32*c -: 8]  = gmul(a0,m3)^gmul(a1,m0)^gmul(a2,m1)^gmul(a3,m2);
      r[111-32*c -: 8]  = gmul(a0,m2)^gmul(a1,m3)^gmul(a2,m0)^gmul(a3,m1);
      r[103-32*c -: 8]  = gmul(a0,m1)^gmul(a1,m2)^gmul(a2,m3)^gmul(a3,m0);
    end
    return r;
  endfunction

  function automatic logic [1279:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1279:0] all;
    rc = 8'h01;
    all = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 1; r <= 10; r++)
      all[1279-128*(r-1) -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return all;
  endfunction

  function automatic logic [127:0] step(input logic [2:0] c, input logic [127:0] s,
                                        input logic [127:0] k);
    case (c)
      3'd0:    return sub(s, 1'b0);
      3'd1:    return shift(s, 1'b0);
      3'd2:    return mix(s, 1'b0);
      3'd3:    return s ^ k;
      3'd4:    return sub(s, 1'b1);
      3'd5:    return shift(s, 1'b1);
      3'd6:    return mix(s, 1'b1);
      default: return 128'hx;
    endcase
  endfunction

  logic [127:0] ek [11];
  logic [6:0]   exp_q [$];
  logic [127:0] m_state, exp_out;
  int           n_op, n_kx, t_acc, t_out;
  logic [2:0]   first_code;
  logic [127:0] first_key;

  task automatic build_exp(input logic [127:0] key, input bit dec);
    logic [1279:0] all;
    all = expand(key);
    ek[0] = key;
    for (int i = 1; i <= 10; i++) ek[i] = all[1279-128*(i-1) -: 128];
    exp_q.delete();
    if (!dec) begin
      exp_q.push_back({3'd3, 4'd0});
      for (int r = 1; r <= 9; r++) begin
        exp_q.push_back({3'd0, 4'(r)});
        exp_q.push_back({3'd1, 4'(r)});
        exp_q.push_back({3'd2, 4'(r)});
        exp_q.push_back({3'd3, 4'(r)});
      end
      exp_q.push_back({3'd0, 4'd10});
      exp_q.push_back({3'd1, 4'd10});
      exp_q.push_back({3'd3, 4'd10});
    end else begin
      exp_q.push_back({3'd3, 4'd10});
      for (int r = 9; r >= 1; r--) begin
        exp_q.push_back({3'd5, 4'(r)});
        exp_q.push_back({3'd4, 4'(r)});
        exp_q.push_back({3'd3, 4'(r)});
        exp_q.push_back({3'd6, 4'(r)});
      end
      exp_q.push_back({3'd5, 4'd0});
      exp_q.push_back({3'd4, 4'd0});
      exp_q.push_back({3'd3, 4'd0});
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] b, input bit dec);
    logic [127:0] s;
    s = b;
    if (!dec) begin
      s = s ^ ek[0];
      for (int r = 1; r <= 10; r++) begin
        s = shift(sub(s, 1'b0), 1'b0);
        if (r < 10) s = mix(s, 1'b0);
        s = s ^ ek[r];
      end
    end else begin
      s = s ^ ek[10];
      for (int r = 9; r >= 0; r--) begin
        s = sub(shift(s, 1'b1), 1'b1) ^ ek[r];
        if (r > 0) s = mix(s, 1'b1);
      end
    end
    return s;
  endfunction

  // Datapath model, latency 1
  always @(posedge clk) begin
    op_done <= op_valid;
    if (op_valid) op_result <= step(op_code, op_data, op_key);
  end

  // Key expander model: keys_valid 4 cycles after kx_start
  int            kx_cnt = 0;
  logic          kv_r = 1'b0;
  logic [1279:0] rk_good = '0;
  bit            kv_early = 1'b0;
  always @(posedge clk) begin
    if (kx_start) begin
      kx_cnt  <= 3;
      rk_good <= expand(kx_key);
    end else if (kx_cnt > 0) begin
      kx_cnt <= kx_cnt - 1;
    end
    kv_r <= (kx_cnt == 1) && !kx_start;
  end
  assign keys_valid = kv_r | (kv_early & kx_start);
  assign rk_in = kv_r ? rk_good : {40{32'hdeadbeef}};

  bit           busy = 1'b0;
  logic         p_ov = 1'b0, p_or = 1'b0;
  logic [127:0] p_ob = '0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy = 1'b0; p_ov = 1'b0; p_or = 1'b0;
    end else begin
      logic [6:0] e;
      chk("in_ready", 128'(in_ready), 128'(!busy));
      if (kx_start) begin
        n_kx++;
        chk("kx_key", kx_key, ek[0]);
      end
      if (op_valid) begin
        chk("op_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("op_code", 128'(op_code), 128'(e[6:4]));
          chk("op_data", op_data, m_state);
          if (e[6:4] == 3'd3) chk("op_key", op_key, ek[e[3:0]]);
          if (n_op == 0) begin
            first_code = op_code;
            first_key  = op_key;
          end
          m_state = step(e[6:4], m_state, ek[e[3:0]]);
        end
        n_op++;
      end
      if (out_valid && !p_ov) begin
        t_out = cyc;
        chk("out_block", out_block, exp_out);
        chk("ops_left", 128'(exp_q.size()), 128'd0);
      end
      if (out_valid && p_ov && !p_or) chk("out_hold", out_block, p_ob);
      if (in_valid && in_ready) busy = 1'b1;
      if (out_valid && out_ready) busy = 1'b0;
      p_ov = out_valid; p_or = out_ready; p_ob = out_block;
    end
  end

  task automatic send(input logic [127:0] blk, input logic [127:0] key, input bit dec);
    int w;
    build_exp(key, dec);
    exp_out = aes_ref(blk, dec);
    m_state = blk;
    n_op = 0; n_kx = 0; t_out = -1;
    w = 0;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1; w++;
    end
    chk("accept_wait", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_block = blk;
    in_key   = key;
`ifdef AES_SEQ_DECRYPT_EN
    in_decrypt = dec;
`endif
    t_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!out_valid && w < 300) begin
      @(posedge clk); #1; w++;
    end
    chk("done_wait", 128'(out_valid), 128'd1);
    @(negedge clk); #1;
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_kx_start", 128'(kx_start), 128'd0);
    chk("rst_op_valid", 128'(op_valid), 128'd0);
    chk("rst_op_code", 128'(op_code), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_op_data", op_data, 128'd0);
    chk("rst_op_key", op_key, 128'd0);
    chk("rst_kx_key", kx_key, 128'd0);
  endtask

  initial begin
    logic [7:0] p;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
      sbox[x] = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

    chk("model_sbox53", 128'(sbox[8'h53]), 128'h ed);
    chk("model_isboxed", 128'(isbox[8'hed]), 128'h53);
    build_exp(K1, 1'b0);
    chk("model_rk10", ek[10], RK10);
    chk("model_enc1", aes_ref(P1, 1'b0), C1);
    chk("model_dec1", aes_ref(C1, 1'b1), P1);
    build_exp(K2, 1'b0);
    chk("model_enc2", aes_ref(P2, 1'b0), C2);
    exp_q.delete();

    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    @(posedge clk); #1;

    send(P1, K1, 1'b0);
    wait_done();
    chk("fips_out", out_block, C1);
    chk("fips_kx", 128'(n_kx), 128'd1);
    chk("fips_ops", 128'(n_op), 128'd40);
    chk("fips_first_key", first_key, K1);
    chk("miss_latency", 128'(t_out - t_acc), 128'd86);
    @(posedge clk); #1;

    send(128'd0, K1, 1'b0);
    wait_done();
    chk("hit_kx", 128'(n_kx), 128'd0);
    chk("hit_latency", 128'(t_out - t_acc), 128'd81);
    chk("hit_ops", 128'(n_op), 128'd40);
    @(posedge clk); #1;

    kv_early = 1'b1;
    send(P2, K2, 1'b0);
    wait_done();
    kv_early = 1'b0;
    chk("chg_out", out_block, C2);
    chk("chg_kx", 128'(n_kx), 128'd1);
    chk("chg_latency", 128'(t_out - t_acc), 128'd86);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(P1, K2, 1'b0);
    wait_done();
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("bp_valid", 128'(out_valid), 128'd1);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_block", out_block, exp_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);

    send(128'h0123456789abcdeffedcba9876543210, K2, 1'b0);
    chk("rst_hit_kx", 128'(n_kx), 128'd0);
    for (int w = 0; w < 300 && n_op < 18; w++) begin
      @(posedge clk); #1;
    end
    chk("op17_reached", 128'(n_op), 128'd18);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ops", 128'(n_op), 128'd18);
    send(P2, K2, 1'b0);
    wait_done();
    chk("post_rst_kx", 128'(n_kx), 128'd1);
    chk("post_rst_out", out_block, C2);
    @(posedge clk); #1;

`ifdef AES_SEQ_DECRYPT_EN
    send(C1, K1, 1'b1);
    wait_done();
    chk("dec_out", out_block, P1);
    chk("dec_first_code", 128'(first_code), 128'd3);
    chk("dec_first_key", first_key, RK10);
    chk("dec_ops", 128'(n_op), 128'd40);
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
